// File: rtl/imem_responder_pkg.sv
// Shared instruction-memory definitions.
// Holds the default address/instruction widths used by the responder and
// its interface, the encoding of the response error flag, and a small
// helper used by the address decoder.
package imem_responder_pkg;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_INSN_W = 32;

    // Encoding of rsp_err: a faulting fetch (misaligned or out of range)
    // returns RSP_ERR together with an all-zero instruction word.
    typedef enum logic {
        RSP_OK  = 1'b0,
        RSP_ERR = 1'b1
    } rsp_err_e;

    // Instructions are word aligned; any non-zero low byte-address bits fault.
    function automatic logic addr_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch <-> instruction memory bus.
// Request side : req_valid, req_addr (fetch drives), req_stall (memory drives).
// Response side: rsp_valid, rsp_insn, rsp_addr, rsp_err (memory drives),
//                rsp_stall (fetch drives).
// Redirect     : flush (fetch drives).
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_stall=0; fetch keeps req_valid/req_addr steady while req_stall=1.
// A response transfers on a rising edge where rsp_valid=1 and rsp_stall=0;
// the memory keeps rsp_valid and the payload steady while rsp_stall=1.
// Stall signals never depend combinationally on the other side's valid.
interface imem_responder_if
    import imem_responder_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int INSN_W = IMEM_INSN_W
);

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_stall;
    logic              rsp_valid;
    logic [INSN_W-1:0] rsp_insn;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              rsp_stall;
    logic              flush;

    // Fetch unit side.
    modport master (
        output req_valid, req_addr, rsp_stall, flush,
        input  req_stall, rsp_valid, rsp_insn, rsp_addr, rsp_err
    );

    // Instruction memory side.
    modport slave (
        input  req_valid, req_addr, rsp_stall, flush,
        output req_stall, rsp_valid, rsp_insn, rsp_addr, rsp_err
    );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Response queue for the instruction memory responder.
// Ports: clk, rst (async active-low), flush (empties the queue; a push on
// the same edge is kept as the sole entry), push/push_data, pop,
// head_data (entry at the read pointer, valid when count != 0), count.
// Pointers wrap modulo DEPTH; full/empty are judged from count only, so
// DEPTH need not be a power of two.
module imem_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_idx;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        wr_idx = wr_q;
        if (flush) begin
            // The queue restarts at slot 0; a same-edge push lands there.
            wr_idx = '0;
            rd_d   = '0;
            wr_d   = push ? ptr_inc('0) : '0;
            cnt_d  = push ? CNT_W'(1) : '0;
        end else begin
            if (push) wr_d = ptr_inc(wr_q);
            if (pop)  rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: nothing reads it while count is 0.
    always_ff @(posedge clk) begin
        if (push) slot_q[wr_idx] <= push_data;
    end

    assign head_data = slot_q[rd_q];
    assign count     = cnt_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder.
// A preloadable word memory answering fetch requests in order with a fixed
// LATENCY, plus a response queue that absorbs fetch back-pressure.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   bus (slave)       request/response/flush bus, see imem_responder_if
//   ld_en/ld_addr/ld_data  preload write port (word index), ignored in reset
// Data path: the memory is read combinationally at the accepting edge, the
// result travels LATENCY-1 pipeline registers and is pushed into the queue
// on the LATENCY-th edge; the queue head drives the response outputs.
// The outstanding count caps everything in flight at OUT_DEPTH, so the
// queue always has room for the last pipeline stage and the pipeline never
// needs to stall.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int INSN_W    = IMEM_INSN_W,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_responder_if.slave          bus,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [INSN_W-1:0]        ld_data
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PW     = 1 + ADDR_W + INSN_W;
    localparam int OCNT_W = $clog2(OUT_DEPTH + 1);

    // ---------------- memory ----------------
    logic [INSN_W-1:0] mem_q [DEPTH];

    // Contents survive reset; the reset branch only blocks preload writes
    // while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // ---------------- acceptance ----------------
    logic              req_stall;
    logic              accept;
    logic              retire;
    logic              rsp_valid;
    logic [IDX_W-1:0]  req_idx;
    logic              req_fault;
    logic              err_code;
    logic [INSN_W-1:0] acc_insn;
    logic [PW-1:0]     acc_payload;

    logic [OCNT_W-1:0] outstanding_q, outstanding_d;

    assign req_stall = (outstanding_q == OCNT_W'(OUT_DEPTH));
    assign accept    = bus.req_valid && !req_stall;
    assign retire    = rsp_valid && !bus.rsp_stall;

    // Any address bit above the word index range means out of range.
    assign req_idx     = bus.req_addr[IDX_W+1:2];
    assign req_fault   = addr_misaligned(bus.req_addr[1:0]) ||
                         ((bus.req_addr >> (IDX_W + 2)) != '0);
    assign err_code    = req_fault ? RSP_ERR : RSP_OK;
    // Read at the accepting edge: a same-edge preload is not yet visible.
    assign acc_insn    = req_fault ? '0 : mem_q[req_idx];
    assign acc_payload = {err_code, bus.req_addr, acc_insn};

    always_comb begin
        outstanding_d = outstanding_q;
        if (bus.flush) begin
            // The request taken on the flush edge belongs to the new stream.
            outstanding_d = accept ? OCNT_W'(1) : '0;
        end else begin
            outstanding_d = outstanding_q + OCNT_W'(accept) - OCNT_W'(retire);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) outstanding_q <= '0;
        else      outstanding_q <= outstanding_d;
    end

    // ---------------- pipeline ----------------
    logic          fifo_push;
    logic [PW-1:0] fifo_push_data;

    if (LATENCY == 1) begin : g_direct
        // Single-cycle latency: the accepting edge writes the queue itself.
        assign fifo_push      = accept;
        assign fifo_push_data = acc_payload;
    end else begin : g_pipe
        localparam int NS = LATENCY - 1;

        logic [NS-1:0] pv_q, pv_d;
        logic [PW-1:0] pd_q [NS];
        logic [PW-1:0] pd_d [NS];

        always_comb begin
            // Stage 0 takes the new request even on a flush edge.
            pv_d[0] = accept;
            pd_d[0] = acc_payload;
            for (int i = 1; i < NS; i++) begin
                pv_d[i] = pv_q[i-1] && !bus.flush;
                pd_d[i] = pd_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv_q <= '0;
                for (int i = 0; i < NS; i++) pd_q[i] <= '0;
            end else begin
                pv_q <= pv_d;
                for (int i = 0; i < NS; i++) pd_q[i] <= pd_d[i];
            end
        end

        assign fifo_push      = pv_q[NS-1] && !bus.flush;
        assign fifo_push_data = pd_q[NS-1];
    end

    // ---------------- response queue ----------------
    logic [PW-1:0]     fifo_head;
    logic [OCNT_W-1:0] fifo_count;

    imem_rsp_fifo #(
        .WIDTH (PW),
        .DEPTH (OUT_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (retire),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign rsp_valid     = (fifo_count != '0);
    assign bus.rsp_valid = rsp_valid;
    assign bus.req_stall = req_stall;
    // Payload outputs read as zero whenever no response is presented.
    assign {bus.rsp_err, bus.rsp_addr, bus.rsp_insn} = rsp_valid ? fifo_head : '0;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam int ADDR_W    = 32;
    localparam int INSN_W    = 32;
    localparam int DEPTH     = 256;
    localparam int LATENCY   = 2;
    localparam int OUT_DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              ld_en;
    logic [7:0]        ld_addr;
    logic [INSN_W-1:0] ld_data;

    imem_responder_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) bus ();

    imem_responder #(
        .ADDR_W    (ADDR_W),
        .INSN_W    (INSN_W),
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [INSN_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [31:0] insn,
                           input logic [31:0] addr, input logic err);
        chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(v));
        chk({tag, "_insn"},  64'(bus.rsp_insn),  64'(insn));
        chk({tag, "_addr"},  64'(bus.rsp_addr),  64'(addr));
        chk({tag, "_err"},   64'(bus.rsp_err),   64'(err));
    endtask

    task automatic chk_idle(input string tag);
        chk_rsp(tag, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] addr);
        bus.req_valid = v;
        bus.req_addr  = addr;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_stall = 1'b0;
        bus.flush     = 1'b0;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;

        // Reset values
        #1;
        chk_idle("reset");
        chk("reset_req_stall", 64'(bus.req_stall), 64'd0);
        tick();
        tick();
        rst = 1'b1;

        load(8'd0, 32'h1111_1111);
        load(8'd1, 32'h2222_2222);
        load(8'd2, 32'h3333_3333);
        load(8'd3, 32'h4444_4444);
        load(8'd4, 32'h5555_5555);
        load(8'd5, 32'h0BAD_F00D);
        chk_idle("after_preload");

        // Back-to-back fetches: first response after 2 edges, then one per cycle
        drive_req(1'b1, 32'h0);  tick();
        chk_idle("b2b_lat");
        drive_req(1'b1, 32'h4);  tick();
        chk_rsp("b2b_0", 1'b1, 32'h1111_1111, 32'h0, 1'b0);
        drive_req(1'b1, 32'h8);  tick();
        chk_rsp("b2b_1", 1'b1, 32'h2222_2222, 32'h4, 1'b0);
        drive_req(1'b1, 32'hC);  tick();
        chk_rsp("b2b_2", 1'b1, 32'h3333_3333, 32'h8, 1'b0);
        drive_req(1'b0, 32'h0);  tick();
        chk_rsp("b2b_3", 1'b1, 32'h4444_4444, 32'hC, 1'b0);
        tick();
        chk_idle("b2b_drained");

        // Faulting fetches: misaligned, then out of range
        drive_req(1'b1, 32'h2);   tick();
        drive_req(1'b1, 32'h400); tick();
        chk_rsp("err_misalign", 1'b1, 32'h0, 32'h2, 1'b1);
        drive_req(1'b0, 32'h0);   tick();
        chk_rsp("err_range", 1'b1, 32'h0, 32'h400, 1'b1);
        tick();
        chk_idle("err_drained");

        // Back-pressure: exactly OUT_DEPTH accepted, head held
        bus.rsp_stall = 1'b1;
        chk("bp_stall_0", 64'(bus.req_stall), 64'd0);
        drive_req(1'b1, 32'h0);  tick();
        chk("bp_stall_1", 64'(bus.req_stall), 64'd0);
        chk_idle("bp_lat");
        drive_req(1'b1, 32'h4);  tick();
        chk("bp_stall_2", 64'(bus.req_stall), 64'd0);
        chk_rsp("bp_head_a", 1'b1, 32'h1111_1111, 32'h0, 1'b0);
        drive_req(1'b1, 32'h8);  tick();
        chk("bp_stall_3", 64'(bus.req_stall), 64'd0);
        drive_req(1'b1, 32'hC);  tick();
        chk("bp_stall_full", 64'(bus.req_stall), 64'd1);
        drive_req(1'b1, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_hold", 64'(bus.req_stall), 64'd1);
            chk_rsp("bp_head_hold", 1'b1, 32'h1111_1111, 32'h0, 1'b0);
        end
        exp_q.push_back(32'h2222_2222); exp_addr_q.push_back(32'h4);
        exp_q.push_back(32'h3333_3333); exp_addr_q.push_back(32'h8);
        exp_q.push_back(32'h4444_4444); exp_addr_q.push_back(32'hC);
        drive_req(1'b0, 32'h0);
        bus.rsp_stall = 1'b0;
        while (exp_q.size() > 0) begin
            tick();
            chk_rsp("bp_drain", 1'b1, exp_q.pop_front(), exp_addr_q.pop_front(), 1'b0);
        end
        tick();
        chk_idle("bp_drained");
        chk("bp_stall_clear", 64'(bus.req_stall), 64'd0);

        // Flush with two in flight; redirect request on the flush edge survives
        bus.rsp_stall = 1'b1;
        drive_req(1'b1, 32'h0);  tick();
        drive_req(1'b1, 32'h4);  tick();
        chk_rsp("fl_before", 1'b1, 32'h1111_1111, 32'h0, 1'b0);
        bus.rsp_stall = 1'b0;
        bus.flush     = 1'b1;
        drive_req(1'b1, 32'h10); tick();
        bus.flush     = 1'b0;
        drive_req(1'b0, 32'h0);
        chk_idle("fl_cleared");
        chk("fl_req_stall", 64'(bus.req_stall), 64'd0);
        tick();
        chk_rsp("fl_redirect", 1'b1, 32'h5555_5555, 32'h10, 1'b0);
        tick();
        chk_idle("fl_no_stale_0");
        tick();
        chk_idle("fl_no_stale_1");

        // Same-edge preload returns old data; the next fetch sees the new word
        ld_en   = 1'b1;
        ld_addr = 8'd5;
        ld_data = 32'hDEAD_BEEF;
        drive_req(1'b1, 32'h14); tick();
        ld_en   = 1'b0;
        drive_req(1'b1, 32'h14); tick();
        chk_rsp("ld_old", 1'b1, 32'h0BAD_F00D, 32'h14, 1'b0);
        drive_req(1'b0, 32'h0);  tick();
        chk_rsp("ld_new", 1'b1, 32'hDEAD_BEEF, 32'h14, 1'b0);
        tick();
        chk_idle("ld_drained");

        // Reset mid-operation with three outstanding
        bus.rsp_stall = 1'b1;
        drive_req(1'b1, 32'h0);  tick();
        drive_req(1'b1, 32'h4);  tick();
        drive_req(1'b1, 32'h8);  tick();
        drive_req(1'b0, 32'h0);
        chk_rsp("rst_busy", 1'b1, 32'h1111_1111, 32'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("rst_async");
        chk("rst_async_stall", 64'(bus.req_stall), 64'd0);
        ld_en   = 1'b1;
        ld_addr = 8'd0;
        ld_data = 32'hFFFF_FFFF;
        tick();
        tick();
        ld_en         = 1'b0;
        rst           = 1'b1;
        bus.rsp_stall = 1'b0;
        tick();
        chk_idle("rst_no_stale_0");
        tick();
        chk_idle("rst_no_stale_1");
        drive_req(1'b1, 32'h0);  tick();
        drive_req(1'b0, 32'h0);
        chk_idle("rst_new_lat");
        tick();
        chk_rsp("rst_new_rsp", 1'b1, 32'h1111_1111, 32'h0, 1'b0);
        tick();
        chk_idle("rst_new_drained");

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
